// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store, with one-cycle read return.
// Optional starvation guard for fetch is enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halted,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              if_stall,
  output logic [1:0]        owner_dbg
);

  // Handshake: a requester holds req and its payload until it sees gnt in the
  // same cycle; exactly one cycle later the matching valid pulses once.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  owner_e owner_q, owner_d;
  logic   fetch_ok;
  logic   force_if;

  assign fetch_ok = if_req & ~halted & ~rst;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_q, starve_d;

  assign force_if = (starve_q == CNT_W'(STARVE_LIMIT));

  // Counts only cycles in which fetch could have gone but lost to data.
  always_comb begin
    starve_d = '0;
    if (fetch_ok && !if_gnt) begin
      starve_d = force_if ? starve_q : starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = if_addr;
    ram_wdata = dm_wdata;
    owner_d   = OWN_NONE;
    if (fetch_ok && (!dm_req || force_if)) begin
      if_gnt  = 1'b1;
      ram_en  = 1'b1;
      owner_d = OWN_IF;
    end else if (dm_req && !rst) begin
      dm_gnt   = 1'b1;
      ram_en   = 1'b1;
      ram_we   = dm_we;
      ram_addr = dm_addr;
      owner_d  = OWN_DM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) owner_q <= OWN_NONE;
    else     owner_q <= owner_d;
  end

  // Read data is passed straight through; the owner tag selects who sees valid.
  assign if_valid  = (owner_q == OWN_IF);
  assign dm_valid  = (owner_q == OWN_DM);
  assign if_rdata  = ram_rdata;
  assign dm_rdata  = ram_rdata;
  assign if_stall  = if_req & ~if_gnt;
  assign owner_dbg = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model; honours MEM_ARB_STARVE_GUARD_EN like the design.
module tb_mem_port_arbiter;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LIM = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          halted = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_valid;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_gnt, dm_valid;
  logic [DW-1:0] dm_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          if_stall;
  logic [1:0]    owner_dbg;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .halted(halted),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .if_stall(if_stall), .owner_dbg(owner_dbg)
  );

  // synchronous single-port RAM behind the arbiter
  logic [DW-1:0] ram [1024];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  // reference model state
  logic [DW-1:0] exp_mem [1024];
  logic [DW-1:0] exp_q[$];
  int            m_owner;     // 0 none, 1 fetch, 2 data
  logic          m_dm_read;
  logic [DW-1:0] m_data;
  int            m_run;       // consecutive lost fetch opportunities

  logic          e_if_gnt, e_dm_gnt, e_en, e_we, e_stall, e_ifv, e_dmv, e_rd_chk;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cycles  = 0;

  // Drives one cycle at the falling edge and predicts what the DUT must show.
  task automatic cyc(input logic r, input logic ir, input logic [AW-1:0] ia,
                     input logic dr, input logic dw, input logic [AW-1:0] da,
                     input logic [DW-1:0] wd, input logic h);
    logic fetch_ok, force_f;
    @(negedge clk);
    rst = r; if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw;
    dm_addr = da; dm_wdata = wd; halted = h;
    #1;
    if (r) begin
      m_owner = 0;
      m_run   = 0;
    end
    e_ifv    = (m_owner == 1);
    e_dmv    = (m_owner == 2);
    e_rd_chk = (m_owner == 1) || (m_owner == 2 && m_dm_read);
    e_data   = m_data;
    fetch_ok = ir && !h && !r;
    force_f  = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    force_f  = (m_run >= LIM);
`endif
    e_if_gnt = fetch_ok && (!dr || force_f);
    e_dm_gnt = dr && !r && !e_if_gnt;
    e_en     = e_if_gnt || e_dm_gnt;
    e_we     = e_dm_gnt && dw;
    e_addr   = e_dm_gnt ? da : ia;
    e_stall  = ir && !e_if_gnt;
    m_run    = (fetch_ok && !e_if_gnt) ? m_run + 1 : 0;
    m_owner  = e_if_gnt ? 1 : (e_dm_gnt ? 2 : 0);
    m_dm_read = !dw;
    if (e_en && !e_we) m_data = exp_mem[e_addr];
    if (e_we) exp_mem[da] = wd;
    cycles++;
  endtask

  task automatic test_reset();
    cyc(1, 1, 10'd7, 1, 0, 10'd9, '0, 0);
    n_tests++;
    if ({if_gnt, dm_gnt, ram_en, ram_we, if_valid, dm_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b want=000000",
               {if_gnt, dm_gnt, ram_en, ram_we, if_valid, dm_valid});
    end
    n_tests++;
    if (if_stall !== 1'b1) begin
      n_fail++; $display("FAIL reset_stall got=%b want=1", if_stall);
    end
    // first grant right after release
    cyc(0, 1, 10'd7, 0, 0, '0, '0, 0);
    n_tests++;
    if (if_gnt !== 1'b1 || ram_addr !== 10'd7) begin
      n_fail++; $display("FAIL first_grant if_gnt=%b addr=%0d want 1/7", if_gnt, ram_addr);
    end
    cyc(0, 0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic test_fetch();
    ram[5] = 32'h2801000A; exp_mem[5] = 32'h2801000A;
    cyc(0, 1, 10'd5, 0, 0, '0, '0, 0);
    n_tests++;
    if ({if_gnt, dm_gnt, ram_en, ram_we} !== 4'b1010 || ram_addr !== 10'd5) begin
      n_fail++;
      $display("FAIL fetch_grant got=%b addr=%0d want=1010 addr=5",
               {if_gnt, dm_gnt, ram_en, ram_we}, ram_addr);
    end
    cyc(0, 0, '0, 0, 0, '0, '0, 0);
    n_tests++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h2801000A || dm_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_return ifv=%b data=%h dmv=%b want 1/2801000a/0",
               if_valid, if_rdata, dm_valid);
    end
    cyc(0, 0, '0, 0, 0, '0, '0, 0);
    n_tests++;
    if (if_valid !== 1'b0) begin
      n_fail++; $display("FAIL fetch_single_pulse ifv=%b want 0", if_valid);
    end
  endtask

  task automatic test_contention();
    exp_q.push_back(exp_mem[100]);
    cyc(0, 1, 10'd3, 1, 0, 10'd100, '0, 0);
    n_tests++;
    if ({dm_gnt, if_gnt, if_stall} !== 3'b101 || ram_addr !== 10'd100) begin
      n_fail++;
      $display("FAIL contention_grant dm/if/stall=%b addr=%0d want 101/100",
               {dm_gnt, if_gnt, if_stall}, ram_addr);
    end
    cyc(0, 1, 10'd3, 0, 0, '0, '0, 0);
    n_tests++;
    if (dm_valid !== 1'b1 || dm_rdata !== exp_q[0] || if_gnt !== 1'b1 || ram_addr !== 10'd3) begin
      n_fail++;
      $display("FAIL contention_followup dmv=%b data=%h ifg=%b addr=%0d want 1/%h/1/3",
               dm_valid, dm_rdata, if_gnt, ram_addr, exp_q[0]);
    end
    void'(exp_q.pop_front());
    cyc(0, 0, '0, 0, 0, '0, '0, 0);
    n_tests++;
    if (if_valid !== 1'b1 || dm_valid !== 1'b0 || if_rdata !== exp_mem[3]) begin
      n_fail++;
      $display("FAIL contention_fetch_return ifv=%b dmv=%b data=%h", if_valid, dm_valid, if_rdata);
    end
  endtask

  task automatic test_store();
    cyc(0, 0, '0, 1, 1, 10'd50, 32'h0000_0055, 0);
    n_tests++;
    if ({dm_gnt, ram_en, ram_we} !== 3'b111 || ram_addr !== 10'd50 || ram_wdata !== 32'h55) begin
      n_fail++;
      $display("FAIL store_cmd got=%b addr=%0d wd=%h want 111/50/55",
               {dm_gnt, ram_en, ram_we}, ram_addr, ram_wdata);
    end
    cyc(0, 0, '0, 1, 0, 10'd50, '0, 0);
    n_tests++;
    if (dm_valid !== 1'b1 || ram_we !== 1'b0) begin
      n_fail++; $display("FAIL store_ack dmv=%b ram_we=%b want 1/0", dm_valid, ram_we);
    end
    cyc(0, 0, '0, 0, 0, '0, '0, 0);
    n_tests++;
    if (dm_valid !== 1'b1 || dm_rdata !== 32'h0000_0055) begin
      n_fail++; $display("FAIL store_readback dmv=%b data=%h want 1/00000055", dm_valid, dm_rdata);
    end
  endtask

  task automatic test_halt();
    cyc(0, 1, 10'd12, 0, 0, '0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 10'd13, (i % 2 == 0), 0, 10'(200 + i), '0, 1);
      if (i == 0) begin
        n_tests++;
        if (if_valid !== 1'b1 || if_rdata !== exp_mem[12]) begin
          n_fail++;
          $display("FAIL halt_inflight_fetch ifv=%b data=%h want 1/%h", if_valid, if_rdata, exp_mem[12]);
        end
      end
      n_tests++;
      if (if_gnt !== 1'b0 || if_stall !== 1'b1 || dm_gnt !== (i % 2 == 0)) begin
        n_fail++;
        $display("FAIL halt_cycle%0d ifg=%b stall=%b dmg=%b want 0/1/%b",
                 i, if_gnt, if_stall, dm_gnt, (i % 2 == 0));
      end
    end
    cyc(0, 1, 10'd13, 0, 0, '0, '0, 0);
    cyc(0, 0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic test_guard();
    int n_ifg = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 10'd20, 1, 0, 10'd21, '0, 0);
      if (if_gnt) n_ifg++;
      n_tests++;
      if ({if_gnt, dm_gnt, ram_en, if_stall} !== {e_if_gnt, e_dm_gnt, e_en, e_stall}) begin
        n_fail++;
        $display("FAIL guard_cycle%0d got=%b want=%b", i,
                 {if_gnt, dm_gnt, ram_en, if_stall}, {e_if_gnt, e_dm_gnt, e_en, e_stall});
      end
    end
    n_tests++;
`ifdef MEM_ARB_STARVE_GUARD_EN
    if (n_ifg != 3) begin
      n_fail++; $display("FAIL guard_fetch_count got=%0d want=3", n_ifg);
    end
`else
    if (n_ifg != 0) begin
      n_fail++; $display("FAIL guard_fetch_count got=%0d want=0", n_ifg);
    end
`endif
    cyc(0, 0, '0, 0, 0, '0, '0, 0);
    cyc(0, 0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic test_reset_mid_read();
    cyc(0, 0, '0, 1, 0, 10'd300, '0, 0);
    n_tests++;
    if (dm_gnt !== 1'b1) begin
      n_fail++; $display("FAIL midread_grant dmg=%b want 1", dm_gnt);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    m_owner = 0;
    m_run   = 0;
    #1;
    n_tests++;
    if ({dm_valid, if_valid, ram_en, ram_we, dm_gnt, if_gnt} !== 6'b0) begin
      n_fail++;
      $display("FAIL midread_reset_outputs got=%b want=000000",
               {dm_valid, if_valid, ram_en, ram_we, dm_gnt, if_gnt});
    end
    cyc(1, 0, '0, 0, 0, '0, '0, 0);
    cyc(0, 0, '0, 0, 0, '0, '0, 0);
    n_tests++;
    if (dm_valid !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL midread_no_return dmv=%b ifv=%b want 0/0", dm_valid, if_valid);
    end
  endtask

  task automatic test_random();
    logic          p_if = 0, p_dm = 0, p_dw = 0, h;
    logic [AW-1:0] p_ia = '0, p_da = '0;
    logic [DW-1:0] p_wd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p_if && $urandom_range(0, 1) == 1) begin
        p_if = 1; p_ia = 10'($urandom_range(0, 31));
      end
      if (!p_dm && $urandom_range(0, 2) != 0) begin
        p_dm = 1; p_dw = 1'($urandom_range(0, 1));
        p_da = 10'($urandom_range(0, 31)); p_wd = $urandom;
      end
      h = ($urandom_range(0, 7) == 0);
      cyc(0, p_if, p_ia, p_dm, p_dw, p_da, p_wd, h);
      n_tests++;
      if ({if_gnt, dm_gnt, ram_en, ram_we, if_stall, if_valid, dm_valid} !==
          {e_if_gnt, e_dm_gnt, e_en, e_we, e_stall, e_ifv, e_dmv} ||
          (e_en && ram_addr !== e_addr) || (e_we && ram_wdata !== p_wd)) begin
        n_fail++;
        $display("FAIL random_ctl cyc%0d got=%b addr=%0d want=%b addr=%0d", i,
                 {if_gnt, dm_gnt, ram_en, ram_we, if_stall, if_valid, dm_valid}, ram_addr,
                 {e_if_gnt, e_dm_gnt, e_en, e_we, e_stall, e_ifv, e_dmv}, e_addr);
      end
      if (e_rd_chk) begin
        n_tests++;
        if ((e_ifv ? if_rdata : dm_rdata) !== e_data) begin
          n_fail++;
          $display("FAIL random_data cyc%0d got=%h want=%h", i,
                   (e_ifv ? if_rdata : dm_rdata), e_data);
        end
      end
      if (e_if_gnt) p_if = 0;
      if (e_dm_gnt) p_dm = 0;
    end
    cyc(0, 0, '0, 0, 0, '0, '0, 0);
  endtask

  initial begin
    logic [DW-1:0] v;
    m_owner = 0; m_run = 0; m_dm_read = 0; m_data = '0;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      ram[i] = v;
      exp_mem[i] = v;
    end
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_halt();
    test_guard();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, word address width (1024-word unified memory).
REQ-002 The block SHALL have parameter DATA_W, default 32, memory word width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 3, consecutive fetch denials before a forced fetch grant (used only with MEM_ARB_STARVE_GUARD_EN).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset; all state SHALL be on the clock's rising edge.
REQ-005 Port: clk  input  1  single system clock.
REQ-006 Port: rst  input  1  asynchronous active-high reset.
REQ-007 Port: halted  input  1  pipeline halted; blocks fetch grants.
REQ-008 Port: if_req, if_addr  input  1, ADDR_W  instruction-fetch request and word address.
REQ-009 Port: if_gnt  output  1  fetch granted this cycle.
REQ-010 Port: if_valid, if_rdata  output  1, DATA_W  fetch data return.
REQ-011 Port: dm_req, dm_we, dm_addr, dm_wdata  input  1, 1, ADDR_W, DATA_W  load/store request.
REQ-012 Port: dm_gnt  output  1  data access granted this cycle.
REQ-013 Port: dm_valid, dm_rdata  output  1, DATA_W  load data return or store acknowledge.
REQ-014 Port: ram_en, ram_we, ram_addr, ram_wdata  output  1, 1, ADDR_W, DATA_W  single-port RAM command.
REQ-015 Port: ram_rdata  input  DATA_W  RAM read data, valid one cycle after ram_en with ram_we=0.
REQ-016 Port: if_stall  output  1  if_req high and if_gnt low this cycle.

Function
REQ-017 At most one of if_gnt, dm_gnt SHALL be high in any cycle.
REQ-018 Grants SHALL be combinational from the current-cycle requests and state; the RAM command SHALL be driven in the grant cycle.
REQ-019 Default priority: dm_req granted over if_req when both present.
REQ-020 if_gnt SHALL never assert while halted=1; dm_gnt is unaffected by halted.
REQ-021 No request: ram_en=0, ram_we=0, both gnt=0.
REQ-022 Granted cycle N: ram_en=1, ram_addr=owner address, ram_we=dm_we if data owner else 0, ram_wdata=dm_wdata.
REQ-023 Owner tag register (states NONE, IF, DM) SHALL record the owner of cycle N; in cycle N+1 the tagged requester's valid SHALL pulse for exactly one cycle.
REQ-024 if_rdata/dm_rdata SHALL equal ram_rdata in the owner's valid cycle; dm_valid SHALL also pulse for stores (ack), with dm_rdata don't-care.
REQ-025 Back-to-back grants SHALL be supported every cycle: throughput one access per cycle, latency one cycle.
REQ-026 A requester SHALL hold req/addr/we/wdata stable until its gnt; the block SHALL not queue requests.
REQ-027 if_stall SHALL equal if_req & ~if_gnt, including while halted.
REQ-028 Asserting halted with a fetch in flight SHALL still deliver that fetch's if_valid in the next cycle.

Reset
REQ-029 While rst=1: if_gnt, dm_gnt, if_valid, dm_valid, ram_en, ram_we = 0; owner tag = NONE; starve counter = 0; if_stall = if_req.
REQ-030 Reset asserted mid-access SHALL cancel the pending return: no valid pulse after deassertion.
REQ-031 First grant SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-032 Macro MEM_ARB_STARVE_GUARD_EN SHALL select the starvation guard.
REQ-033 Defined: a counter SHALL count consecutive cycles with if_req=1, halted=0, if_gnt=0; when it equals STARVE_LIMIT, the next contending cycle SHALL grant fetch over data; counter clears on any if_gnt or if_req=0 or halted=1.
REQ-034 Not defined: strict data-over-fetch priority, no counter logic present.

Verification
REQ-035 Fetch only: if_req=1, if_addr=5, RAM[5]=32'h2801000A -> if_gnt at N, if_valid=1 with if_rdata=32'h2801000A at N+1, dm_valid=0.
REQ-036 Contention: if_req=1 addr 3, dm_req=1 dm_we=0 addr 100 same cycle -> dm_gnt=1, if_gnt=0, if_stall=1; next cycle dm_valid with RAM[100], fetch granted.
REQ-037 Store: dm_req=1, dm_we=1, addr 50, wdata 32'h0000_0055 -> ram_we=1, dm_valid ack at N+1; later load of addr 50 returns 32'h0000_0055.
REQ-038 Halt: halted=1, if_req=1 for 5 cycles -> if_gnt=0, if_stall=1 each cycle; dm_req still granted.
REQ-039 Guard (macro on, STARVE_LIMIT=3): dm_req and if_req held continuously -> 3 dm grants, then 1 if grant, repeating; macro off -> if_gnt never asserts.
REQ-040 Reset mid-read: rst pulse in cycle N+1 after a granted load -> dm_valid stays 0, all outputs at reset values.
